// File: rtl/lcd_bit_sequencer.sv
// lcd_bit_sequencer
// Accepts a 32-bit LCD word over valid/ready and latches it. It then steps the
// 32:1 bit-select decoder through every bit, one bit per LCD serial clock. It
// also generates sclk, the active-low chip select, and frame status.
//
// Optional build macro: LCD_SEQ_MSB_FIRST_EN
//   defined   -> bits are sent MSB first (sel 31 down to 0)
//   undefined -> bits are sent LSB first (sel 0 up to 31)
//
// Ports:
//   clk, rst            system clock, async active-high reset
//   word_in, word_valid word to serialize and its valid strobe
//   word_ready          high while idle (a word can be accepted)
//   div                 sclk half-period minus one, sampled at accept
//   data_word, sel, en  drive the decoder (data_in, sel, enable)
//   sclk, cs_n          LCD serial clock (idle low) and chip select
//   busy, done          frame in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for a word; cs_n high, sclk low
// LOW   | sclk low for H cycles; decoder output settles
// HIGH  | sclk high for H cycles; LCD samples on the rising edge
// HOLD  | sclk low, cs_n still low for H cycles (CS hold time)
`timescale 1ns/1ps
module lcd_bit_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [DIV_W-1:0] div,
  output logic [31:0]      data_word,
  output logic [4:0]       sel,
  output logic             en,
  output logic             sclk,
  output logic             cs_n,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

`ifdef LCD_SEQ_MSB_FIRST_EN
  localparam logic [4:0] FIRST_IDX = 5'd31;
  localparam logic [4:0] LAST_IDX  = 5'd0;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
  localparam logic [4:0] LAST_IDX  = 5'd31;
`endif

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [4:0]       sel_next;

`ifdef LCD_SEQ_MSB_FIRST_EN
  assign sel_next = sel - 5'd1;
`else
  assign sel_next = sel + 5'd1;
`endif

  assign word_ready = (state == IDLE);

  // Each phase loads cnt with div_q on entry. The phase ends on the cycle in
  // which cnt is 0, so every phase lasts div_q+1 cycles. The counter never
  // counts past div_q, so an all-ones div cannot overflow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_q     <= '0;
      cnt       <= '0;
      data_word <= '0;
      sel       <= '0;
      en        <= 1'b0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid) begin
            data_word <= word_in;
            div_q     <= div;
            cnt       <= div;
            sel       <= FIRST_IDX;
            en        <= 1'b1;
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            state     <= LOW;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            cnt   <= div_q;
            sclk  <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            cnt  <= div_q;
            sclk <= 1'b0;
            if (sel == LAST_IDX) begin
              state <= HOLD;
            end else begin
              sel   <= sel_next;
              state <= LOW;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs_n  <= 1'b1;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bit_sequencer.sv
`timescale 1ns/1ps
module tb_lcd_bit_sequencer;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      word_in = '0;
  logic             word_valid = 1'b0;
  logic             word_ready;
  logic [DIV_W-1:0] div = '0;
  logic [31:0]      data_word;
  logic [4:0]       sel;
  logic             en, sclk, cs_n, busy, done;

  int checks = 0;
  int errors = 0;

  lcd_bit_sequencer #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .div(div), .data_word(data_word), .sel(sel),
    .en(en), .sclk(sclk), .cs_n(cs_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit index sent for the b-th serial bit of a frame.
  function automatic int idx(input int b);
`ifdef LCD_SEQ_MSB_FIRST_EN
    return 31 - b;
`else
    return b;
`endif
  endfunction

  // Reference model: a frame is just a cycle offset n from the first busy
  // cycle. Phase p = n / H. Phases 0..63 alternate sclk low/high for bit p/2,
  // and phase 64 is the CS hold. The frame occupies 65*H cycles.
  bit          m_active = 0;
  int          m_n = 0;
  int          m_h = 1;
  logic [31:0] m_word = '0;
  int          m_sel = 0;
  bit          m_done = 0;
  int          m_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_n = 0; m_h = 1; m_word = '0; m_sel = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        m_n++;
        if (m_n == 65 * m_h) begin
          m_active = 0;
          m_done   = 1;
          m_sel    = idx(31);
        end
      end else if (word_valid) begin
        m_active = 1;
        m_n      = 0;
        m_h      = int'(div) + 1;
        m_word   = word_in;
        m_accepts++;
      end
    end
  end

  int rises = 0;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    int p, e_sel;
    bit e_sclk;
    p = m_n / m_h;
    e_sclk = m_active && (p < 64) && (p % 2 == 1);
    e_sel  = !m_active ? m_sel : (p < 64 ? idx(p / 2) : idx(31));
    chk("busy",       busy,       m_active);
    chk("en",         en,         m_active);
    chk("cs_n",       cs_n,       !m_active);
    chk("word_ready", word_ready, !m_active);
    chk("sclk",       sclk,       e_sclk);
    chk("sel",        sel,        e_sel);
    chk("data_word",  data_word,  m_word);
    chk("done",       done,       m_done);
    chk("dec_out",    data_word[sel], m_active ? m_word[e_sel] : m_word[m_sel]);
    chk("done_busy_excl", done & busy, 0);
    if (rst) rises = 0;
    else if (sclk && !prev_sclk) rises++;
    prev_sclk = sclk;
    if (m_done) begin
      chk("sclk_rises", rises, 32);
      rises = 0;
    end
  end

  task automatic wait_idle(input bit jitter);
    int n = 0;
    do begin
      @(negedge clk); #1;
      if (jitter) begin
        div     = DIV_W'($urandom);
        word_in = $urandom;
      end
      n++;
    end while (m_active && n < 20000);
    if (m_active) chk("idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [31:0] w, input logic [DIV_W-1:0] d);
    @(negedge clk); #1;
    word_in = w; div = d; word_valid = 1'b1;
    @(negedge clk); #1;
    word_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Reset mid-frame: outputs drop asynchronously and no done follows.
    send(32'hA5A5_A5A5, 8'd3);
    repeat (38) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_en",   en,   0);
    chk("rst_data", data_word, 0);
    chk("rst_ready", word_ready, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    send(32'h0000_0001, 8'd0);  wait_idle(0);
    send(32'hFFFF_0000, 8'd3);  wait_idle(0);
    send(32'h8000_0000, 8'd0);  wait_idle(0);

    // word_valid held across two frames; the second is taken in the done cycle.
    @(negedge clk); #1;
    word_in = 32'h1234_5678; div = 8'd1; word_valid = 1'b1;
    @(negedge clk); #1;
    word_in = 32'h8765_4321;
    n = 0;
    while (m_accepts < 7 && n < 2000) begin @(negedge clk); n++; end
    chk("b2b_accepts", m_accepts, 7);
    #1 word_valid = 1'b0;
    wait_idle(0);

    // div changed mid-frame must not affect the running frame.
    send(32'hC3C3_3C3C, 8'd1);
    repeat (10) @(negedge clk);
    #1 div = 8'd7;
    wait_idle(0);
    send(32'h0F0F_F0F0, 8'd7);  wait_idle(0);

    // Largest divider: H = 256.
    send(32'h5555_AAAA, 8'hFF); wait_idle(0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send($urandom, DIV_W'($urandom_range(0, 5)));
      wait_idle(1);
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
